// File: rtl/sprite_pkg.sv
// Shared sprite-pipeline constants, FSM encoding and slot payload type.
// Also imported by the pixel compositor.
package sprite_pkg;

  localparam int unsigned NUM_SPRITES  = 20;
  localparam int unsigned MAX_PER_LINE = 8;
  localparam int unsigned SPRITE_H     = 16;
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned ROW_W        = 4;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned Y_W          = 16;
  localparam int unsigned NY_W         = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [ROW_W-1:0] row;
  } slot_t;

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// Sprite table read port: index/strobe out, Y/active back one cycle later.
interface sprite_line_scheduler_if;
  import sprite_pkg::*;

  logic             tbl_rd_en;
  logic [IDX_W-1:0] tbl_rd_idx;
  logic [Y_W-1:0]   tbl_y;
  logic             tbl_active;

  modport master (output tbl_rd_en, output tbl_rd_idx, input tbl_y, input tbl_active);
  modport slave  (input tbl_rd_en, input tbl_rd_idx, output tbl_y, output tbl_active);

endinterface

// File: rtl/sprite_hit_cmp.sv
// Combinational scanline/sprite intersection test and row-within-sprite.
module sprite_hit_cmp
  import sprite_pkg::*;
(
  input  logic [NY_W-1:0]  line_y,
  input  logic [Y_W-1:0]   spr_y,
  input  logic             spr_active,
  output logic             hit_c,
  output logic [ROW_W-1:0] row_c
);

  logic [Y_W-1:0] line_y16;
  logic [Y_W-1:0] diff;

  // Sprites starting below the line are rejected before the difference is trusted.
  always_comb begin
    line_y16 = Y_W'(line_y);
    diff     = line_y16 - spr_y;
    hit_c    = spr_active && (line_y16 >= spr_y) && (diff < Y_W'(SPRITE_H));
    row_c    = diff[ROW_W-1:0];
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-line sprite evaluator: scans the table during hblank and publishes
// up to MAX_PER_LINE hits in index order, plus an overflow flag.
module sprite_line_scheduler
  import sprite_pkg::*;
(
  input  logic                            pixel_clk,
  input  logic                            reset,
  input  logic                            line_start,
  input  logic [NY_W-1:0]                 next_y,
  sprite_line_scheduler_if.master         tbl,
  output logic                            busy,
  output logic                            done,
  output logic [MAX_PER_LINE-1:0]         slot_valid,
  output logic [MAX_PER_LINE*IDX_W-1:0]   slot_idx,
  output logic [MAX_PER_LINE*ROW_W-1:0]   slot_row,
  output logic [CNT_W-1:0]                sprite_count,
  output logic                            overflow
);

  state_t           state;
  logic [NY_W-1:0]  line_y;
  logic             eval_vld;
  logic [IDX_W-1:0] eval_idx;
  logic             hit_c;
  logic [ROW_W-1:0] row_c;
  logic             last_eval_c;

  slot_t            wk_slots   [MAX_PER_LINE];
  slot_t            wk_slots_n [MAX_PER_LINE];
  slot_t            pub_slots  [MAX_PER_LINE];
  logic [CNT_W-1:0] wk_cnt, wk_cnt_n, pub_cnt;
  logic             wk_ovf, wk_ovf_n, pub_ovf;

  sprite_hit_cmp u_hit_cmp (
    .line_y     (line_y),
    .spr_y      (tbl.tbl_y),
    .spr_active (tbl.tbl_active),
    .hit_c      (hit_c),
    .row_c      (row_c)
  );

  // Working list with the entry currently on the read-data bus folded in.
  always_comb begin
    wk_slots_n = wk_slots;
    wk_cnt_n   = wk_cnt;
    wk_ovf_n   = wk_ovf;
    if (eval_vld && hit_c) begin
      if (wk_cnt == CNT_W'(MAX_PER_LINE)) begin
        wk_ovf_n = 1'b1;
      end else begin
        for (int k = 0; k < int'(MAX_PER_LINE); k++) begin
          if (wk_cnt == CNT_W'(k)) wk_slots_n[k] = '{valid: 1'b1, idx: eval_idx, row: row_c};
        end
        wk_cnt_n = wk_cnt + CNT_W'(1);
      end
    end
  end

  assign last_eval_c = eval_vld && (eval_idx == IDX_W'(NUM_SPRITES - 1));

  // line_start (re)starts a scan from any state; an aborted scan publishes nothing.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      tbl.tbl_rd_en  <= 1'b0;
      tbl.tbl_rd_idx <= '0;
      line_y         <= '0;
      eval_vld       <= 1'b0;
      eval_idx       <= '0;
      wk_cnt         <= '0;
      wk_ovf         <= 1'b0;
      pub_cnt        <= '0;
      pub_ovf        <= 1'b0;
      for (int k = 0; k < int'(MAX_PER_LINE); k++) begin
        wk_slots[k]  <= '0;
        pub_slots[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (line_start) begin
        state          <= SCAN;
        line_y         <= next_y;
        busy           <= 1'b1;
        tbl.tbl_rd_en  <= 1'b1;
        tbl.tbl_rd_idx <= '0;
        eval_vld       <= 1'b0;
        eval_idx       <= '0;
        wk_cnt         <= '0;
        wk_ovf         <= 1'b0;
        for (int k = 0; k < int'(MAX_PER_LINE); k++) wk_slots[k] <= '0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          SCAN: begin
            if (tbl.tbl_rd_en) begin
              if (tbl.tbl_rd_idx == IDX_W'(NUM_SPRITES - 1)) begin
                tbl.tbl_rd_en  <= 1'b0;
                tbl.tbl_rd_idx <= '0;
              end else begin
                tbl.tbl_rd_idx <= tbl.tbl_rd_idx + IDX_W'(1);
              end
            end
            eval_vld <= tbl.tbl_rd_en;
            eval_idx <= tbl.tbl_rd_idx;
            wk_slots <= wk_slots_n;
            wk_cnt   <= wk_cnt_n;
            wk_ovf   <= wk_ovf_n;
            if (last_eval_c) begin
              pub_slots <= wk_slots_n;
              pub_cnt   <= wk_cnt_n;
              pub_ovf   <= wk_ovf_n;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    slot_valid = '0;
    slot_idx   = '0;
    slot_row   = '0;
    for (int k = 0; k < int'(MAX_PER_LINE); k++) begin
      slot_valid[k]                = pub_slots[k].valid;
      slot_idx[k*IDX_W +: IDX_W]   = pub_slots[k].idx;
      slot_row[k*ROW_W +: ROW_W]   = pub_slots[k].row;
    end
  end

  assign sprite_count = pub_cnt;
  assign overflow     = pub_ovf;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler against a behavioural table model.
module tb_sprite_line_scheduler;
  import sprite_pkg::*;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [9:0]  next_y;
  logic        busy, done, overflow;
  logic [7:0]  slot_valid;
  logic [39:0] slot_idx;
  logic [31:0] slot_row;
  logic [3:0]  sprite_count;

  sprite_line_scheduler_if tbl_if ();

  sprite_line_scheduler dut (
    .pixel_clk    (pixel_clk),
    .reset        (reset),
    .line_start   (line_start),
    .next_y       (next_y),
    .tbl          (tbl_if),
    .busy         (busy),
    .done         (done),
    .slot_valid   (slot_valid),
    .slot_idx     (slot_idx),
    .slot_row     (slot_row),
    .sprite_count (sprite_count),
    .overflow     (overflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_y   [20];
  logic        mem_act [20];
  logic [84:0] exp_vec;
  int          exp_cnt;
  wire  [84:0] pub_vec = {slot_valid, slot_idx, slot_row, sprite_count, overflow};

  // Sprite table with one cycle of read latency; garbage when not read.
  always @(posedge pixel_clk) begin
    if (tbl_if.tbl_rd_en && tbl_if.tbl_rd_idx < 5'd20) begin
      tbl_if.tbl_y      <= mem_y[tbl_if.tbl_rd_idx];
      tbl_if.tbl_active <= mem_act[tbl_if.tbl_rd_idx];
    end else begin
      tbl_if.tbl_y      <= 16'($urandom);
      tbl_if.tbl_active <= 1'($urandom);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_tbl();
    for (int i = 0; i < 20; i++) begin
      mem_act[i] = 1'b0;
      mem_y[i]   = 16'($urandom);
    end
  endtask

  // Reference: walk the table in index order, keep the first eight hits.
  task automatic model(input logic [9:0] ny);
    int c, d;
    logic ovf;
    logic [7:0] v;
    logic [39:0] ix;
    logic [31:0] rw;
    c = 0; ovf = 1'b0; v = '0; ix = '0; rw = '0;
    for (int i = 0; i < 20; i++) begin
      d = int'(ny) - int'(mem_y[i]);
      if (mem_act[i] && d >= 0 && d < 16) begin
        if (c < 8) begin
          v[c] = 1'b1;
          ix[c*5 +: 5] = 5'(i);
          rw[c*4 +: 4] = 4'(d);
          c++;
        end else begin
          ovf = 1'b1;
        end
      end
    end
    exp_cnt = c;
    exp_vec = {v, ix, rw, 4'(c), ovf};
  endtask

  // Pulses line_start in the current cycle and observes until done or a budget expires.
  task automatic run_scan(input logic [9:0] ny, output int done_cyc, output int rd_cnt,
                          output int seq_err, output int pub_chg);
    logic [84:0] pub0;
    int cyc;
    pub0 = pub_vec;
    line_start = 1'b1;
    next_y = ny;
    @(posedge pixel_clk); #1;
    line_start = 1'b0;
    next_y = 10'($urandom);
    cyc = 1; done_cyc = -1; rd_cnt = 0; seq_err = 0; pub_chg = 0;
    while (done_cyc < 0 && cyc <= 40) begin
      if (tbl_if.tbl_rd_en) begin
        rd_cnt++;
        if (tbl_if.tbl_rd_idx !== 5'(cyc - 1)) seq_err++;
      end
      if (tbl_if.tbl_rd_en !== (cyc >= 1 && cyc <= 20)) seq_err++;
      if (busy !== (cyc >= 1 && cyc <= 21)) seq_err++;
      if (done === 1'b1) done_cyc = cyc;
      else begin
        if (pub_vec !== pub0) pub_chg = 1;
        @(posedge pixel_clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; line_start = 1'b0; next_y = '0;
    clear_tbl();
    repeat (3) @(posedge pixel_clk);
    #1;
    checks++;
    if ({pub_vec, busy, done, tbl_if.tbl_rd_en, tbl_if.tbl_rd_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {pub_vec, busy, done, tbl_if.tbl_rd_en, tbl_if.tbl_rd_idx});
    end
    reset = 1'b0;
    begin
      int act = 0;
      repeat (10) begin
        @(posedge pixel_clk); #1;
        if (tbl_if.tbl_rd_en || busy || done) act++;
      end
      checks++;
      if (act != 0) begin
        errors++;
        $display("FAIL idle_quiet: %0d active cycles, required 0", act);
      end
    end
  endtask

  task automatic test_basic();
    int dc, rc, se, pc;
    clear_tbl();
    foreach (mem_y[i]) mem_y[i] = 16'd400;
    mem_act[2] = 1'b1; mem_act[7] = 1'b1; mem_act[19] = 1'b1;
    mem_y[2] = 16'd100; mem_y[7] = 16'd100; mem_y[19] = 16'd100;
    model(10'd105);
    run_scan(10'd105, dc, rc, se, pc);
    checks++;
    if (dc != 22) begin errors++; $display("FAIL basic_done_cycle: got %0d required 22", dc); end
    checks++;
    if (rc != 20) begin errors++; $display("FAIL basic_rd_count: got %0d required 20", rc); end
    checks++;
    if (se != 0) begin errors++; $display("FAIL basic_sequence: %0d strobe/busy errors, required 0", se); end
    checks++;
    if (pc != 0) begin errors++; $display("FAIL basic_stable: published changed mid-scan"); end
    checks++;
    if (sprite_count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d required 3", sprite_count); end
    checks++;
    if (pub_vec !== exp_vec) begin errors++; $display("FAIL basic_list: got %h required %h", pub_vec, exp_vec); end
    @(posedge pixel_clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done still %b one cycle later", done); end
  endtask

  task automatic test_boundary();
    int dc, rc, se, pc;
    clear_tbl();
    foreach (mem_y[i]) mem_y[i] = 16'd900;
    mem_act[0] = 1'b1; mem_y[0] = 16'd185;
    mem_act[1] = 1'b1; mem_y[1] = 16'd184;
    mem_act[2] = 1'b1; mem_y[2] = 16'd200;
    mem_act[3] = 1'b1; mem_y[3] = 16'd201;
    mem_act[4] = 1'b0; mem_y[4] = 16'd200;
    mem_act[5] = 1'b1; mem_y[5] = 16'hFFF0;
    model(10'd200);
    run_scan(10'd200, dc, rc, se, pc);
    checks++;
    if (dc != 22) begin errors++; $display("FAIL bound_done_cycle: got %0d required 22", dc); end
    checks++;
    if (sprite_count !== 4'd2) begin errors++; $display("FAIL bound_count: got %0d required 2", sprite_count); end
    checks++;
    if (pub_vec !== exp_vec) begin errors++; $display("FAIL bound_list: got %h required %h", pub_vec, exp_vec); end
  endtask

  task automatic test_overflow();
    int dc, rc, se, pc;
    clear_tbl();
    foreach (mem_y[i]) mem_y[i] = 16'd700;
    for (int i = 0; i < 10; i++) begin mem_act[i] = 1'b1; mem_y[i] = 16'd50; end
    model(10'd60);
    run_scan(10'd60, dc, rc, se, pc);
    checks++;
    if ({sprite_count, overflow} !== {4'd8, 1'b1}) begin
      errors++; $display("FAIL ovf_flags: got cnt=%0d ovf=%b required cnt=8 ovf=1", sprite_count, overflow);
    end
    checks++;
    if (pub_vec !== exp_vec) begin errors++; $display("FAIL ovf_list: got %h required %h", pub_vec, exp_vec); end
    run_scan(10'd1000, dc, rc, se, pc);
    checks++;
    if ({pub_vec, dc} !== {85'd0, 32'd22}) begin
      errors++; $display("FAIL ovf_clear: got list %h done %0d required 0 / 22", pub_vec, dc);
    end
  endtask

  task automatic test_random();
    int dc, rc, se, pc, yv;
    logic [9:0] ny;
    for (int it = 0; it < 10; it++) begin
      ny = 10'($urandom);
      for (int i = 0; i < 20; i++) begin
        yv = int'(ny) + int'($urandom_range(0, 24)) - 19;
        mem_y[i]   = (yv < 0 || $urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(yv);
        mem_act[i] = ($urandom_range(0, 3) != 0);
      end
      model(ny);
      run_scan(ny, dc, rc, se, pc);
      checks++;
      if (dc != 22 || se != 0 || pc != 0) begin
        errors++; $display("FAIL rand_timing[%0d]: done %0d seq_err %0d chg %0d required 22/0/0", it, dc, se, pc);
      end
      checks++;
      if (pub_vec !== exp_vec) begin
        errors++; $display("FAIL rand_list[%0d]: ny=%0d got %h required %h", it, ny, pub_vec, exp_vec);
      end
      repeat ($urandom_range(0, 3)) @(posedge pixel_clk);
      #0;
    end
  endtask

  task automatic test_restart();
    int dc, rc, se, pc, bad;
    logic [84:0] pub0;
    clear_tbl();
    foreach (mem_y[i]) mem_y[i] = 16'd800;
    mem_act[3]  = 1'b1; mem_y[3]  = 16'd290;
    mem_act[11] = 1'b1; mem_y[11] = 16'd495;
    mem_act[15] = 1'b1; mem_y[15] = 16'd300;
    pub0 = pub_vec;
    @(posedge pixel_clk); #1;
    line_start = 1'b1; next_y = 10'd500;
    bad = 0;
    for (int c = 1; c < 10; c++) begin
      @(posedge pixel_clk); #1;
      line_start = 1'b0;
      if (done || pub_vec !== pub0) bad++;
    end
    @(posedge pixel_clk); #1;
    model(10'd300);
    run_scan(10'd300, dc, rc, se, pc);
    checks++;
    if (bad != 0 || pc != 0) begin errors++; $display("FAIL restart_hold: %0d early cycles bad, chg %0d, required 0", bad, pc); end
    checks++;
    if (dc != 22) begin errors++; $display("FAIL restart_done_cycle: got %0d required 22", dc); end
    checks++;
    if (pub_vec !== exp_vec) begin errors++; $display("FAIL restart_list: got %h required %h", pub_vec, exp_vec); end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2, rc, se, pc;
    clear_tbl();
    foreach (mem_y[i]) mem_y[i] = 16'd600;
    mem_act[2] = 1'b1; mem_act[7] = 1'b1; mem_act[19] = 1'b1;
    mem_y[2] = 16'd100; mem_y[7] = 16'd100; mem_y[19] = 16'd100;
    run_scan(10'd105, dc1, rc, se, pc);
    model(10'd110);
    run_scan(10'd110, dc2, rc, se, pc);
    checks++;
    if (dc1 != 22 || dc2 != 22 || se != 0) begin
      errors++; $display("FAIL b2b_timing: done %0d/%0d seq_err %0d required 22/22/0", dc1, dc2, se);
    end
    checks++;
    if (pub_vec !== exp_vec) begin errors++; $display("FAIL b2b_list: got %h required %h", pub_vec, exp_vec); end
  endtask

  task automatic test_reset_mid();
    int dc, rc, se, pc, bad;
    @(posedge pixel_clk); #1;
    line_start = 1'b1; next_y = 10'd105;
    @(posedge pixel_clk); #1;
    line_start = 1'b0;
    repeat (11) @(posedge pixel_clk);
    #1;
    reset = 1'b1;
    @(posedge pixel_clk); #1;
    checks++;
    if ({pub_vec, busy, done, tbl_if.tbl_rd_en} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %h required 0", {pub_vec, busy, done, tbl_if.tbl_rd_en});
    end
    reset = 1'b0;
    bad = 0;
    repeat (30) begin
      @(posedge pixel_clk); #1;
      if (done || busy || tbl_if.tbl_rd_en) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_quiet: %0d active cycles, required 0", bad); end
    model(10'd105);
    run_scan(10'd105, dc, rc, se, pc);
    checks++;
    if (dc != 22 || rc != 20 || pub_vec !== exp_vec) begin
      errors++; $display("FAIL midreset_rescan: done %0d rd %0d list %h required 22/20/%h", dc, rc, pub_vec, exp_vec);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_overflow();
    test_random();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
